// File: rtl/block_interleaver_if.sv
// Serial bit-stream handshake bundle for the block interleaver: write side in, read side out.
interface block_interleaver_if;
  logic data_i;
  logic valid_i;
  logic ready_o;
  logic data_o;
  logic valid_o;
  logic ready_i;
  logic sof_o;

  modport slave (
    input  data_i, valid_i, ready_i,
    output ready_o, data_o, valid_o, sof_o
  );

  modport master (
    output data_i, valid_i, ready_i,
    input  ready_o, data_o, valid_o, sof_o
  );
endinterface

// File: rtl/block_interleaver.sv
// Row/column block interleaver: rows are written into one ping-pong bank while
// the other bank is read out column-major through a registered output stage.
module block_interleaver #(
  parameter int ROWS = 4,
  parameter int COLS = 4
) (
  input  logic           clk,
  input  logic           rst,
  block_interleaver_if.slave bus
);
  localparam int N  = ROWS * COLS;
  localparam int CW = $clog2(N);
  localparam int RW = $clog2(ROWS);

  typedef enum logic [1:0] {EMPTY, FILLING, FULL, DRAINING} bank_st_e;

  bank_st_e        st_q [2];
  bank_st_e        st_d [2];
  logic [N-1:0]    mem  [2];
  logic            wsel, rsel;
  logic [CW-1:0]   wcnt, rcnt;
  logic [CW-1:0]   rd_idx, rcol;
  logic [RW-1:0]   rrow;
  logic            data_q, valid_q, sof_q;
  logic            accept, adv, rd_ok, rd, wlast, rlast;

  assign bus.ready_o = (st_q[wsel] == EMPTY) || (st_q[wsel] == FILLING);
  assign accept      = bus.valid_i && bus.ready_o;
  assign adv         = !valid_q || bus.ready_i;
  assign rd_ok       = (st_q[rsel] == FULL) || (st_q[rsel] == DRAINING);
  assign rd          = adv && rd_ok;
  assign wlast       = (wcnt == CW'(N-1));
  assign rlast       = (rcnt == CW'(N-1));

  assign bus.data_o  = data_q;
  assign bus.valid_o = valid_q;
  assign bus.sof_o   = sof_q;

  // Write and read never touch the same bank in one cycle: the bank states
  // that gate them are mutually exclusive.
  always_comb begin
    st_d[0] = st_q[0];
    st_d[1] = st_q[1];
    if (accept) st_d[wsel] = wlast ? FULL  : FILLING;
    if (rd)     st_d[rsel] = rlast ? EMPTY : DRAINING;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      st_q[0] <= EMPTY;
      st_q[1] <= EMPTY;
    end else begin
      st_q[0] <= st_d[0];
      st_q[1] <= st_d[1];
    end
  end

  always_ff @(posedge clk) begin
    if (accept) mem[wsel][wcnt] <= bus.data_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wsel <= 1'b0;
      wcnt <= '0;
    end else if (accept) begin
      wcnt <= wlast ? '0 : wcnt + CW'(1);
      if (wlast) wsel <= ~wsel;
    end
  end

  // rd_idx tracks (rcnt % ROWS)*COLS + rcnt/ROWS incrementally: step by COLS
  // down a column, then jump to the top of the next column.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsel    <= 1'b0;
      rcnt    <= '0;
      rd_idx  <= '0;
      rcol    <= '0;
      rrow    <= '0;
      data_q  <= 1'b0;
      valid_q <= 1'b0;
      sof_q   <= 1'b0;
    end else if (adv) begin
      if (rd_ok) begin
        data_q  <= mem[rsel][rd_idx];
        valid_q <= 1'b1;
        sof_q   <= (rcnt == '0);
        if (rlast) begin
          rcnt   <= '0;
          rd_idx <= '0;
          rcol   <= '0;
          rrow   <= '0;
          rsel   <= ~rsel;
        end else begin
          rcnt <= rcnt + CW'(1);
          if (rrow == RW'(ROWS-1)) begin
            rrow   <= '0;
            rcol   <= rcol + CW'(1);
            rd_idx <= rcol + CW'(1);
          end else begin
            rrow   <= rrow + RW'(1);
            rd_idx <= rd_idx + CW'(COLS);
          end
        end
      end else begin
        valid_q <= 1'b0;
        sof_q   <= 1'b0;
      end
    end
  end
endmodule

// File: tb/tb_block_interleaver.sv
// Scoreboard bench for block_interleaver: a block-level interleave model feeds
// an expected queue that a negedge monitor drains against the DUT output.
module tb_block_interleaver;
  localparam int ROWS = 4;
  localparam int COLS = 4;
  localparam int N    = ROWS * COLS;

  logic clk = 1'b0;
  logic rst;
  block_interleaver_if bus();

  block_interleaver #(.ROWS(ROWS), .COLS(COLS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int vec  = 0;
  int errs = 0;
  int cyc  = 0;
  int acc_cnt = 0;
  bit track = 0;
  int first_acc, first_out, last_out, n_out;

  logic [1:0] exp_q [$];   // {data, sof}
  logic       blk   [$];
  logic       in_log  [$];
  logic       out_log [$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    vec++;
    if (act !== req) begin
      errs++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, req, $time);
    end
  endtask

  // Reference model: bit at row r, column c leaves at position c*ROWS + r.
  task automatic model_block();
    logic ob [N];
    for (int r = 0; r < ROWS; r++)
      for (int c = 0; c < COLS; c++)
        ob[c*ROWS + r] = blk[r*COLS + c];
    for (int j = 0; j < N; j++) exp_q.push_back({ob[j], j == 0});
    blk.delete();
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
  end

  // Monitor: sees transfers that will happen on the next rising edge.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      exp_q.delete();
      blk.delete();
    end else begin
      if (bus.valid_i && bus.ready_o) begin
        acc_cnt++;
        in_log.push_back(bus.data_i);
        if (track && first_acc < 0) first_acc = cyc;
        blk.push_back(bus.data_i);
        if (blk.size() == N) model_block();
      end
      if (bus.valid_o && bus.ready_i) begin
        out_log.push_back(bus.data_o);
        if (track) begin
          if (first_out < 0) first_out = cyc;
          last_out = cyc;
          n_out++;
        end
        if (exp_q.size() == 0) begin
          chk("unexpected output", 32'(bus.valid_o), 32'd0);
        end else begin
          logic [1:0] e;
          e = exp_q.pop_front();
          chk("data_o", 32'(bus.data_o), 32'(e[1]));
          chk("sof_o", 32'(bus.sof_o), 32'(e[0]));
        end
      end
    end
  end

  task automatic do_reset();
    rst = 1'b1;
    bus.valid_i = 1'b0;
    bus.data_i  = 1'b0;
    bus.ready_i = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    acc_cnt = 0;
    in_log.delete();
    out_log.delete();
  endtask

  // Presents one bit until accepted; valid_i/ready_i duty cycles in percent.
  task automatic send_bit(input logic d, input int vpct, input int rpct, input bit chk_rdy);
    bit took = 0;
    int t = 0;
    while (!took) begin
      bus.valid_i = ($urandom_range(99) < vpct);
      bus.data_i  = d;
      bus.ready_i = ($urandom_range(99) < rpct);
      @(negedge clk);
      if (chk_rdy) chk("ready_o during stream", 32'(bus.ready_o), 32'd1);
      took = bus.valid_i && bus.ready_o;
      @(posedge clk);
      #1;
      if (++t > 1000) begin
        chk("send timeout", 32'(took), 32'd1);
        break;
      end
    end
  endtask

  task automatic wait_drain(input int rpct);
    int t = 0;
    bus.valid_i = 1'b0;
    while (exp_q.size() != 0 && t < 3000) begin
      bus.ready_i = ($urandom_range(99) < rpct);
      @(posedge clk);
      #1;
      t++;
    end
    chk("drain timeout", 32'(exp_q.size()), 32'd0);
    bus.ready_i = 1'b1;
    repeat (20) @(posedge clk);
    #1;
  endtask

  int pin  [4] = '{6, 0, 5, 15};
  int pout [4] = '{9, 0, 5, 15};

  initial begin
    // Reset and idle
    do_reset();
    repeat (50) begin
      @(negedge clk);
      chk("idle valid_o", 32'(bus.valid_o), 32'd0);
      chk("idle sof_o",   32'(bus.sof_o),   32'd0);
      chk("idle data_o",  32'(bus.data_o),  32'd0);
      chk("idle ready_o", 32'(bus.ready_o), 32'd1);
    end
    @(posedge clk);
    #1;

    // One-hot permutation
    for (int k = 0; k < 4; k++) begin
      int ones, pos;
      do_reset();
      for (int i = 0; i < N; i++) send_bit(i == pin[k], 100, 100, 0);
      wait_drain(100);
      ones = 0;
      pos  = -1;
      foreach (out_log[j]) if (out_log[j]) begin ones++; pos = j; end
      chk("onehot count", 32'(ones), 32'd1);
      chk("onehot position", 32'(pos), 32'(pout[k]));
    end

    // Continuous streaming
    do_reset();
    first_acc = -1; first_out = -1; last_out = -1; n_out = 0;
    track = 1;
    for (int i = 0; i < 8*N; i++) send_bit(1'($urandom), 100, 100, 1);
    wait_drain(100);
    track = 0;
    chk("first output latency", 32'(first_out - first_acc), 32'd17);
    chk("stream contiguous", 32'(last_out - first_out), 32'(8*N - 1));
    chk("stream count", 32'(n_out), 32'(8*N));

    // Backpressure
    do_reset();
    for (int i = 0; i < 2*N; i++) send_bit(1'($urandom), 100, 0, 0);
    bus.valid_i = 1'b1;
    bus.ready_i = 1'b0;
    repeat (10) begin
      @(negedge clk);
      chk("bp ready_o", 32'(bus.ready_o), 32'd0);
      chk("bp valid_o", 32'(bus.valid_o), 32'd1);
      chk("bp sof_o",   32'(bus.sof_o),   32'd1);
      chk("bp data_o",  32'(bus.data_o),  32'(exp_q.size() > 0 ? exp_q[0][1] : 1'bx));
    end
    chk("bp accepted", 32'(acc_cnt), 32'(2*N));
    @(posedge clk);
    #1;
    for (int i = 0; i < N; i++) send_bit(1'($urandom), 100, 100, 0);
    wait_drain(100);
    chk("bp total out", 32'(out_log.size()), 32'(3*N));

    // Random gaps on both sides, then loop back through deinterleave
    do_reset();
    for (int i = 0; i < 20*N; i++) send_bit(1'($urandom), 50, 70, 0);
    wait_drain(70);
    chk("gaps out count", 32'(out_log.size()), 32'(20*N));
    if (out_log.size() == 20*N && in_log.size() == 20*N) begin
      for (int b = 0; b < 20; b++) begin
        logic [N-1:0] got, want;
        for (int r = 0; r < ROWS; r++)
          for (int c = 0; c < COLS; c++) begin
            got[r*COLS + c]  = out_log[b*N + c*ROWS + r];
            want[r*COLS + c] = in_log[b*N + r*COLS + c];
          end
        chk("deinterleave loop", 32'(got), 32'(want));
      end
    end

    // Async reset mid-block while block 1 drains
    do_reset();
    for (int i = 0; i < N + 7; i++) send_bit(1'($urandom), 100, 100, 0);
    chk("pre-reset valid_o", 32'(bus.valid_o), 32'd1);
    #2 rst = 1'b1;
    #1;
    chk("async rst valid_o", 32'(bus.valid_o), 32'd0);
    chk("async rst sof_o",   32'(bus.sof_o),   32'd0);
    chk("async rst data_o",  32'(bus.data_o),  32'd0);
    chk("async rst ready_o", 32'(bus.ready_o), 32'd1);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    out_log.delete();
    for (int i = 0; i < N; i++) send_bit(1'($urandom), 100, 100, 0);
    wait_drain(100);
    chk("post-reset out count", 32'(out_log.size()), 32'(N));

    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end
endmodule
